// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  localparam int unsigned FRAME_BITS     = 11;
  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FILTER_LEN_DEF = 8;
  localparam int unsigned TIMEOUT_DEF    = 50000;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(logic [DATA_BITS-1:0] data, logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; rd_data reads 0 while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // A push into a full FIFO is allowed when a pop frees a slot in the same cycle.
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: clock filter, frame deserialiser with error checks,
// frame timeout and a scan-code FIFO with sticky error flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       PS2_KBCLK,
  input  logic                       PS2_KBDAT,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       clr_err
);

  localparam int unsigned TW      = $clog2(TIMEOUT+1);
  localparam logic [7:0]  FLT_MAX = 8'(FILTER_LEN-1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [1:0]           clk_sync_q, dat_sync_q;
  logic                 ps2_clk, ps2_dat;
  logic                 filt_q, fall_q;
  logic [7:0]           flt_cnt_q;
  logic [TW-1:0]        tmo_cnt_q;
  logic                 tmo_hit;
  rx_state_e            state_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q, push_data_q;
  logic                 par_q, push_q, perr_ev_q, ferr_ev_q;
  logic                 ovf_ev;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_KBCLK};
      dat_sync_q <= {dat_sync_q[0], PS2_KBDAT};
    end
  end

  assign ps2_clk = clk_sync_q[1];
  assign ps2_dat = dat_sync_q[1];

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (ps2_clk == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_MAX) begin
        filt_q    <= ps2_clk;
        flt_cnt_q <= '0;
        fall_q    <= filt_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + 8'd1;
      end
    end
  end

  assign tmo_hit = (state_q != StIdle) && (tmo_cnt_q == TMO_MAX);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (fall_q || state_q == StIdle) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  // Stop-bit outcome is registered, so the push/flag update lands one cycle later.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_ev_q   <= 1'b0;
      ferr_ev_q   <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      perr_ev_q <= 1'b0;
      ferr_ev_q <= 1'b0;
      if (tmo_hit) begin
        state_q <= StIdle;
      end else if (fall_q) begin
        case (state_q)
          StIdle: begin
            if (!ps2_dat) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {ps2_dat, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS-1)) state_q <= StParity;
          end
          StParity: begin
            par_q   <= ps2_dat;
            state_q <= StStop;
          end
          StStop: begin
            state_q     <= StIdle;
            push_data_q <= shift_q;
            perr_ev_q   <= !parity_ok(shift_q, par_q);
            ferr_ev_q   <= !ps2_dat;
            push_q      <= ps2_dat && parity_ok(shift_q, par_q);
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ovf_ev = push_q & full & ~rd_en;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .wr_en   (push_q),
    .wr_data (push_data_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // Set wins over clr_err.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= (parity_err & ~clr_err) | perr_ev_q;
      frame_err  <= (frame_err & ~clr_err) | ferr_ev_q | tmo_hit;
      overflow   <= (overflow & ~clr_err) | ovf_ev;
    end
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver with a scan-code FIFO. It replaces direct sampling of the PS2_KBCLK/PS2_KBDAT pins inside the core. It filters the asynchronous PS/2 clock, deframes 11-bit device-to-host frames, and checks start, parity and stop bits. Valid scan codes are queued in a show-ahead FIFO that the core drains at its own pace, and errors are reported through sticky flags.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, ≥2.
- FILTER_LEN, 8, consecutive equal samples required before the filtered PS/2 clock changes level; range 2..255.
- TIMEOUT, 50000, CLOCK_50 cycles without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- PS2_KBCLK  in  1  raw PS/2 clock, asynchronous.
- PS2_KBDAT  in  1  raw PS/2 data, asynchronous.
- rd_en  in  1  pop the head byte; ignored while empty.
- rd_data  out  8  head byte of the FIFO; valid while !empty.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds DEPTH bytes.
- count  out  $clog2(DEPTH+1)  number of bytes in the FIFO.
- parity_err  out  1  sticky: a frame failed the odd-parity check.
- frame_err  out  1  sticky: bad stop bit, or frame aborted by timeout.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.
- clr_err  in  1  clears all three sticky flags.

Decided: one clock; reset is asynchronous and active-high.

## Operation
- **Synchroniser:** both pins pass through 2-flop synchronisers.
- **Filter:** the filtered clock flips only after FILTER_LEN consecutive synchronised samples disagree with its current level. Its reset level is 1.
- **Fall strobe:** a one-cycle `fall` pulse is generated on a filtered 1→0 transition. All data sampling happens on `fall`, using the synchronised data.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear bit_cnt. On `fall` with data=1, stay in IDLE and set no flag.
  - DATA: shift the data bit in LSB-first; after 8 bits, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: on `fall`, go to IDLE. The byte is accepted only if stop=1 and the XOR of the 8 data bits and the parity bit is 1.
- **STOP outcomes:**
  - stop=0: set frame_err and discard the byte. A parity failure in the same frame also sets parity_err.
  - Parity bad, stop good: set parity_err and discard the byte.
  - Valid byte with FIFO not full, or full with rd_en asserted in the same cycle: push the byte.
  - Valid byte with FIFO full and rd_en low: drop the byte and set overflow.
- **Timeout:** a counter resets on every `fall` and on entry to IDLE. If it reaches TIMEOUT while the FSM is not in IDLE, the FSM returns to IDLE, frame_err is set, and the partial byte is discarded.
- **Sticky flags vs clr_err:** if a flag-setting event and clr_err occur in the same cycle, the flag is set (set wins).
- **FIFO:**
  - Circular buffer with pointer width log2(DEPTH) and natural wrap.
  - Push and pop in the same cycle: count is unchanged; when empty, no pop occurs and the push proceeds.
  - rd_en while empty has no effect.
- **Reset values:**
  - Pointers, count=0, empty=1, full=0.
  - rd_data=0 (the storage array need not be reset; rd_data is forced to 0 while empty).
  - All flags 0, FSM in IDLE, filtered clock 1.
- **Reset mid-frame:** the partial frame is lost. Remaining edges of the interrupted frame are rejected by the start, parity or stop checks, or by the timeout.

## Timing
- Raw pin edge to `fall`: 2 sync cycles + FILTER_LEN cycles.
- `fall` for the stop bit in cycle t → byte written at the end of cycle t+1. empty, count and full reflect it in cycle t+2.
- Error flags assert in the same cycle as the corresponding write would occur (visible at t+2).
- rd_en in cycle t → rd_data shows the next entry and count decrements in cycle t+1.
- Timeout abort: frame_err becomes visible 1 cycle after the counter reaches TIMEOUT.
- Throughput: one frame per ~11 PS/2 clocks (10–16.7 kHz). The FIFO never blocks the receiver.

## Structure
- Package ps2_pkg holds:
  - the FSM state enum (IDLE/DATA/PARITY/STOP);
  - FRAME_BITS=11 and DATA_BITS=8;
  - default values of FILTER_LEN and TIMEOUT.
- Sub-module sync_fifo(WIDTH=8, DEPTH) contains storage, pointers, count, full and empty.
- Synchroniser, filter, FSM, timeout and flags live in the top module.

## Test plan
- Send a frame for 0x1C (parity 0, stop 1) → empty falls 2 cycles after the stop `fall`; count=1, rd_data=0x1C, no flags; one rd_en → empty=1.
- Send 0xF0 then 0x1C back-to-back → FIFO order is 0xF0, 0x1C; count=2.
- Send 0x5A with its parity bit flipped to 0 → parity_err=1, count stays 0. A pulse on clr_err → parity_err=0.
- With DEPTH=4, send 5 bytes 0x01–0x05 without reading → full=1, count=4, overflow=1, FIFO holds 0x01–0x04. Repeat with rd_en asserted in the 5th byte's push cycle → 0x05 is accepted and overflow stays 0.
- Send a start bit plus 3 data bits, then idle for TIMEOUT+2 cycles → frame_err=1, FSM in IDLE. A following complete 0x1C frame is received correctly.
- Inject glitches of FILTER_LEN-1 cycles on PS2_KBCLK between edges of a 0x1C frame → no extra `fall`, byte received as 0x1C. Assert reset mid-frame → count=0, flags=0 immediately.
